// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Holds the scan state encoding and one-hot decode helpers used by the scanner and its key buffer.
package keypad_scan_pkg;

  localparam int KEY_W = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  // Highest set bit wins, but callers only pass one-hot values.
  function automatic logic [1:0] onehot4_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_scan_key_buf.sv
// One-entry key buffer with valid/ack handshake and a sticky overrun flag.
module keypad_scan_key_buf
  import keypad_scan_pkg::*;
(
  input  logic             led_clk,
  input  logic             rstn,
  input  logic             key_event,
  input  logic [KEY_W-1:0] event_code,
  input  logic             key_ack,
  input  logic             overrun_clr,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             overrun
);

  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             overrun_q, overrun_d;

  // An ack on the same edge as a new event frees the slot for that event; set beats clear on overrun.
  always_comb begin
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    overrun_d   = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (key_event) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = event_code;
        key_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (key_ack && key_valid_q) begin
      key_valid_d = 1'b0;
    end
  end

  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes rows, synchronises and debounces columns,
// and hands decoded keys to a one-entry buffer.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int ROW_DWELL      = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       led_clk,
  input  logic       rstn,
  input  logic [3:0] col_in,
  input  logic       key_ack,
  input  logic       overrun_clr,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic       overrun
);

  localparam int DWELL_W = $clog2(ROW_DWELL);
  localparam int DEB_W   = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(ROW_DWELL - 1);
  localparam logic [DEB_W-1:0]   DEB_MAX    = DEB_W'(DEBOUNCE_SCANS);

  logic [3:0]         col_meta_q, col_s_q;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [3:0]         row_q, row_d;
  scan_state_e        state_q, state_d;
  logic [3:0]         cap_col_q, cap_col_d;
  logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
  logic               key_down_q, key_down_d;

  logic               sample;
  logic [DEB_W-1:0]   deb_inc;
  logic [3:0]         row_adv;
  logic               key_event;
  logic [KEY_W-1:0]   event_code;

  always_comb begin
    sample     = (dwell_q == DWELL_LAST);
    dwell_d    = sample ? '0 : dwell_q + DWELL_W'(1);
    deb_inc    = (deb_cnt_q == DEB_MAX) ? deb_cnt_q : deb_cnt_q + DEB_W'(1);
    row_adv    = {row_q[2:0], row_q[3]};
    event_code = {onehot4_to_idx(row_q), onehot4_to_idx(cap_col_q)};

    state_d   = state_q;
    row_d     = row_q;
    cap_col_d = cap_col_q;
    deb_cnt_d = deb_cnt_q;
    key_event = 1'b0;

    // The row stays frozen while a candidate key is being debounced, held or released.
    if (sample) begin
      case (state_q)
        SCAN: begin
          if (is_onehot4(col_s_q)) begin
            cap_col_d = col_s_q;
            deb_cnt_d = DEB_W'(1);
            state_d   = DEBOUNCE;
          end else begin
            row_d = row_adv;
          end
        end
        DEBOUNCE: begin
          if (col_s_q == cap_col_q) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              state_d   = PRESSED;
              key_event = 1'b1;
            end
          end else begin
            state_d = SCAN;
            row_d   = row_adv;
          end
        end
        PRESSED: begin
          if (col_s_q == 4'd0) begin
            deb_cnt_d = DEB_W'(1);
            state_d   = RELEASE;
          end
        end
        RELEASE: begin
          if (col_s_q == 4'd0) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DEB_MAX) begin
              state_d = SCAN;
              row_d   = row_adv;
            end
          end else begin
            state_d = PRESSED;
          end
        end
      endcase
    end

    key_down_d = (state_d == PRESSED) || (state_d == RELEASE);
  end

  always_ff @(posedge led_clk or negedge rstn) begin
    if (!rstn) begin
      col_meta_q <= '0;
      col_s_q    <= '0;
      dwell_q    <= '0;
      row_q      <= 4'b0001;
      state_q    <= SCAN;
      cap_col_q  <= '0;
      deb_cnt_q  <= '0;
      key_down_q <= 1'b0;
    end else begin
      col_meta_q <= col_in;
      col_s_q    <= col_meta_q;
      dwell_q    <= dwell_d;
      row_q      <= row_d;
      state_q    <= state_d;
      cap_col_q  <= cap_col_d;
      deb_cnt_q  <= deb_cnt_d;
      key_down_q <= key_down_d;
    end
  end

  keypad_scan_key_buf u_key_buf (
    .led_clk     (led_clk),
    .rstn        (rstn),
    .key_event   (key_event),
    .event_code  (event_code),
    .key_ack     (key_ack),
    .overrun_clr (overrun_clr),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .overrun     (overrun)
  );

  assign row_out  = row_q;
  assign key_down = key_down_q;

endmodule
